// File: rtl/piso_tx_sched.sv
// piso_tx_sched: round-robin scheduler for two word requesters feeding one MSB-first serializer
// Each frame holds every bit for div_lat+1 cycles, then spends one DONE cycle before the next grant.
module piso_tx_sched #(
   parameter int WIDTH = 4,
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [DIV_W-1:0] baud_div,
   input  logic             req0_valid,
   input  logic [WIDTH-1:0] req0_data,
   output logic             req0_ready,
   input  logic             req1_valid,
   input  logic [WIDTH-1:0] req1_data,
   output logic             req1_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             sout_first,
   output logic             sout_last,
   output logic             sout_src,
   output logic             busy,
   output logic             done
);
   localparam int CW = $clog2(WIDTH);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
   state_t           r_state, w_next;
   logic [WIDTH-1:0] r_shreg;
   logic [CW-1:0]    r_bit_cnt;
   logic [DIV_W-1:0] r_div_lat, r_div_cnt;
   logic             r_rr, r_src;
   logic             w_gnt, w_acc, w_bit_end, w_shift;
   always_ff @(posedge clk) r_state <= reset ? IDLE : w_next;
   always_comb begin
      w_shift    = r_state == SHIFT;
      w_gnt      = (req0_valid & req1_valid) ? r_rr : req1_valid;
      // ready is gated by reset so a word offered during reset is never taken
      w_acc      = (r_state == IDLE) & (req0_valid | req1_valid) & ~reset;
      w_bit_end  = w_shift & (r_div_cnt == '0);
      w_next     = w_acc ? SHIFT :
                   (w_bit_end & (r_bit_cnt == '0)) ? DONE :
                   (r_state == DONE) ? IDLE : r_state;
      req0_ready = w_acc & ~w_gnt;
      req1_ready = w_acc & w_gnt;
      sout       = w_shift & r_shreg[WIDTH-1];
      sout_valid = w_shift;
      sout_first = w_shift & (r_bit_cnt == CW'(WIDTH-1));
      sout_last  = w_shift & (r_bit_cnt == '0);
      sout_src   = r_src;
      busy       = r_state != IDLE;
      done       = r_state == DONE;
   end
   always_ff @(posedge clk) begin
      if (reset) begin
         r_shreg   <= '0;
         r_bit_cnt <= '0;
         r_div_lat <= '0;
         r_div_cnt <= '0;
         r_rr      <= 1'b0;
         r_src     <= 1'b0;
      end else if (w_acc) begin
         r_shreg   <= w_gnt ? req1_data : req0_data;
         r_src     <= w_gnt;
         r_bit_cnt <= CW'(WIDTH-1);
         r_div_lat <= baud_div;
         r_div_cnt <= baud_div;
         r_rr      <= ~w_gnt;
      end else if (w_bit_end) begin
         if (r_bit_cnt != '0) begin
            r_shreg   <= {r_shreg[WIDTH-2:0], 1'b0};
            r_bit_cnt <= r_bit_cnt - CW'(1);
            r_div_cnt <= r_div_lat;
         end
      end else if (w_shift) begin
         r_div_cnt <= r_div_cnt - DIV_W'(1);
      end
   end
endmodule

// File: tb/tb_piso_tx_sched.sv
// tb_piso_tx_sched: randomized and directed checks of piso_tx_sched against a frame-expansion model
// Each accepted word is expanded into its expected per-cycle output sequence in a queue.
module tb_piso_tx_sched;
   localparam int W  = 4;
   localparam int DW = 8;
   logic clk = 0, reset = 1;
   logic [DW-1:0] baud_div = '0;
   logic req0_valid = 0, req1_valid = 0;
   logic [W-1:0] req0_data = '0, req1_data = '0;
   logic req0_ready, req1_ready, sout, sout_valid, sout_first, sout_last, sout_src, busy, done;
   int total = 0, bad = 0;
   typedef struct packed {logic s, v, f, l, src, d;} ent_t;
   ent_t q[$];
   logic m_rr = 0, m_src = 0;
   always #5 clk = ~clk;
   piso_tx_sched #(.WIDTH(W), .DIV_W(DW)) dut (
      .clk(clk), .reset(reset), .baud_div(baud_div),
      .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
      .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
      .sout(sout), .sout_valid(sout_valid), .sout_first(sout_first), .sout_last(sout_last),
      .sout_src(sout_src), .busy(busy), .done(done));
   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask
   task automatic cyc(input logic rst, input logic v0, input logic [W-1:0] d0,
                      input logic v1, input logic [W-1:0] d1, input logic [DW-1:0] bd);
      logic [6:0] eo;
      logic [1:0] er;
      logic g;
      logic [W-1:0] wd;
      @(posedge clk);
      #1;
      reset = rst; req0_valid = v0; req0_data = d0; req1_valid = v1; req1_data = d1; baud_div = bd;
      @(negedge clk);
      g = (v0 & v1) ? m_rr : v1;
      if (q.size() != 0) begin
         eo = {q[0].s, q[0].v, q[0].f, q[0].l, q[0].src, 1'b1, q[0].d};
         er = 2'b00;
      end else begin
         eo = {4'b0000, m_src, 2'b00};
         er = rst ? 2'b00 : {v0 & ~g, v1 & g};
      end
      check("outs{sout,vld,first,last,src,busy,done}",
            {9'd0, sout, sout_valid, sout_first, sout_last, sout_src, busy, done}, {9'd0, eo});
      check("ready{r0,r1}", {14'd0, req0_ready, req1_ready}, {14'd0, er});
      if (rst) begin
         q.delete();
         m_rr = 0;
         m_src = 0;
      end else if (q.size() != 0) begin
         void'(q.pop_front());
      end else if (v0 | v1) begin
         wd = g ? d1 : d0;
         for (int i = W - 1; i >= 0; i--)
            repeat (int'(bd) + 1) q.push_back('{wd[i], 1'b1, i == W - 1, i == 0, g, 1'b0});
         q.push_back('{1'b0, 1'b0, 1'b0, 1'b0, g, 1'b1});
         m_rr = ~g;
         m_src = g;
      end
   endtask
   task automatic idle(input int n, input logic [DW-1:0] bd);
      repeat (n) cyc(0, 0, '0, 0, '0, bd);
   endtask
   initial begin
      repeat (2) @(posedge clk);
      cyc(1, 0, '0, 0, '0, 0);
      cyc(1, 1, 4'hF, 1, 4'hF, 0);
      cyc(0, 1, 4'b1011, 0, '0, 0);
      idle(6, 0);
      cyc(0, 0, '0, 1, 4'b0110, 2);
      idle(14, 0);
      repeat (26) cyc(0, 1, 4'hA, 1, 4'h5, 0);
      idle(3, 0);
      cyc(0, 1, 4'h9, 0, '0, 1);
      repeat (4) cyc(0, 0, 4'h6, 0, 4'h3, 3);
      idle(6, 3);
      cyc(0, 0, '0, 1, 4'hC, 3);
      idle(20, 0);
      cyc(0, 1, 4'hD, 0, '0, 0);
      cyc(0, 0, '0, 0, '0, 0);
      cyc(1, 0, '0, 0, '0, 0);
      cyc(0, 0, '0, 1, 4'h7, 0);
      idle(7, 0);
      cyc(0, 0, '0, 1, 4'h3, 1);
      idle(2, 0);
      cyc(0, 1, 4'hE, 0, '0, 0);
      idle(12, 0);
      cyc(0, 1, 4'h8, 0, '0, 8'hFF);
      idle(W * 256 + 3, 0);
      for (int k = 0; k < 3000; k++)
         cyc(($urandom_range(0, 299) == 0), $urandom_range(0, 1) == 1, W'($urandom),
             $urandom_range(0, 1) == 1, W'($urandom), DW'($urandom_range(0, 3)));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/piso_tx_sched.md
Name: piso_tx_sched

Overview:
- Serial-transmit scheduler that shares one parallel-in/serial-out shift datapath between two requesters.
- Accepts parallel words from two sources over valid/ready handshakes and arbitrates between them round-robin.
- Loads the granted word and shifts it out MSB-first at a programmable bit rate, with frame markers and a completion pulse.
- Sits between the word producers and the serial line driver.

Parameters:
- WIDTH, 4, bits per serialized word (>=2).
- DIV_W, 8, width of the bit-period divider value.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- baud_div  input  DIV_W  clock cycles per serial bit minus 1; latched at word acceptance.
- req0_valid  input  1  requester 0 has a word.
- req0_data  input  WIDTH  requester 0 word.
- req0_ready  output  1  requester 0 word accepted this cycle when valid.
- req1_valid  input  1  requester 1 has a word.
- req1_data  input  WIDTH  requester 1 word.
- req1_ready  output  1  requester 1 word accepted this cycle when valid.
- sout  output  1  serial data bit, MSB first.
- sout_valid  output  1  sout carries a frame bit.
- sout_first  output  1  current bit is the frame MSB.
- sout_last  output  1  current bit is the frame LSB.
- sout_src  output  1  id of the requester owning the current frame.
- busy  output  1  high whenever the block is not in IDLE.
- done  output  1  one-cycle pulse after the last bit period ends.

Behaviour:
- Reset values (reset wins over everything, including mid-frame):
  - state=IDLE, rr pointer=0 (req0 has priority).
  - sout=0, sout_valid=0, sout_first=0, sout_last=0, sout_src=0, busy=0, done=0.
  - Shift register, bit counter and divider counter all 0.
  - A frame in flight is aborted with no done pulse.
- States: IDLE, SHIFT, DONE.
- Ready generation (combinational from state, valids and rr pointer):
  - In IDLE, readyN=1 only for the granted requester. All other states: both ready=0.
  - Grant: if exactly one valid, grant it. If both valid, grant the one the rr pointer names.
- Accept (valid & ready in IDLE):
  - shreg<=granted data; src<=granted id; bit_cnt<=WIDTH-1.
  - div_lat<=baud_div; div_cnt<=baud_div.
  - rr pointer <= the other requester. The pointer does not change when no grant occurs.
  - Next state SHIFT.
- SHIFT:
  - Registered outputs: sout=shreg[WIDTH-1], sout_valid=1, sout_src=src.
  - sout_first=(bit_cnt==WIDTH-1), sout_last=(bit_cnt==0).
  - Each bit is held div_lat+1 cycles. div_cnt decrements every cycle.
  - When div_cnt==0 and bit_cnt>0: shreg<=shreg<<1 (zero fill), bit_cnt--, div_cnt<=div_lat.
  - When div_cnt==0 and bit_cnt==0: next state DONE.
- DONE:
  - Lasts exactly 1 cycle: done=1, sout_valid=0, sout=0. Next state IDLE.
- Latency and throughput:
  - The first bit appears the cycle after acceptance.
  - A frame occupies WIDTH*(baud_div+1) cycles, followed by 1 DONE cycle and at least 1 IDLE cycle before the next accept.
- Boundary conditions:
  - baud_div=0: one cycle per bit.
  - baud_div all-ones: 2^DIV_W cycles per bit, with no overflow since the counter only decrements.
  - baud_div changes during a frame: no effect until the next accept.
  - Data or valid changes during a frame: ignored; data is sampled only at accept.
  - Valid dropped before ready: no accept, no state change.
  - Both valid continuously: grants strictly alternate 0,1,0,1...
  - Reset asserted in the same cycle as an accept: reset wins; the word is not taken.
- Outside SHIFT: sout, sout_valid, sout_first, sout_last are 0. sout_src holds its last value.

Test Plan:
- reset, then baud_div=0, req0 sends 4'b1011 → req0_ready=1 for 1 cycle; sout=1,0,1,1 on 4 consecutive cycles; first on bit 1, last on bit 4; sout_src=0; done the next cycle.
- baud_div=2, req1 sends 4'b0110 → each bit held 3 cycles (12 cycles total); sout_src=1; done at cycle 13 after accept.
- req0 and req1 both held valid with 4'hA and 4'h5 → frames A,5,A,5; the ready pulses alternate starting with req0 after reset.
- Mid-frame: change baud_div from 1 to 3 and change req data → the current frame keeps 2 cycles per bit and its original bits; the new divider applies to the next frame.
- reset asserted during bit 2 of a frame → the next cycle shows all outputs 0, busy=0, no done, rr=0; a following req1-only request is accepted normally.
- req0_valid pulses for 1 cycle while busy, then drops → never accepted; no frame is produced for it.
